// File: rtl/onehot_seq_checker.sv
// Receive-side monitor for the 4-phase one-hot rotating phase bus.
// Decodes the registered sample, tracks phase order, holds lock and reports ordering faults.
module onehot_seq_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       signal,
   output logic [1:0]       index,
   output logic             valid,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] TRACK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam logic [3:0]       LOCK_RUN = 4'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [3:0] sample_q;
   logic [1:0] state, state_d;
   logic [1:0] prev_idx, prev_d;
   logic [3:0] run, run_d;
   logic [1:0] expected;
   logic       advance;
   logic       fault;

   always_comb begin
      valid = 1'b1;
      index = 2'd0;
      case (sample_q)
         4'b1000: index = 2'd0;
         4'b0100: index = 2'd1;
         4'b0010: index = 2'd2;
         4'b0001: index = 2'd3;
         default: valid = 1'b0;
      endcase
   end

   assign expected  = prev_idx + 2'd1;
   assign advance   = valid && (index == expected);
   assign state_dbg = state;

   always_comb begin
      state_d = state;
      prev_d  = prev_idx;
      run_d   = run;
      fault   = 1'b0;
      case (state)
         SEARCH: begin
            if (valid) begin
               state_d = TRACK;
               prev_d  = index;
               run_d   = 4'd0;
            end
         end
         TRACK: begin
            if (!valid) begin
               state_d = SEARCH;
               run_d   = 4'd0;
            end else if (!advance) begin
               prev_d = index;
               run_d  = 4'd0;
            end else begin
               prev_d = index;
               run_d  = run + 4'd1;
               if (run + 4'd1 == LOCK_RUN) state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (advance) begin
               prev_d = index;
            end else if (!valid) begin
               fault   = 1'b1;
               state_d = SEARCH;
               run_d   = 4'd0;
            end else begin
               // Legal but out of order: restart the run from the phase just seen.
               fault   = 1'b1;
               state_d = TRACK;
               prev_d  = index;
               run_d   = 4'd0;
            end
         end
         default: begin
            state_d = SEARCH;
            run_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_q  <= 4'b0000;
         state     <= SEARCH;
         prev_idx  <= 2'd0;
         run       <= 4'd0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         sample_q <= signal;
         state    <= state_d;
         prev_idx <= prev_d;
         run      <= run_d;
         // Registered alongside the state so locked falls on the same edge err rises.
         locked   <= (state_d == LOCKED);
         err      <= fault;
         if (fault && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: doc/onehot_seq_checker.md
# onehot_seq_checker

Receive-side monitor for the 4-phase one-hot rotating signal bus produced by the team's phase sequencer. It samples the 4-bit code every clock, decodes it to a 2-bit phase index, and checks that the phase advances exactly one step per clock (0→1→2→3→0). It also acquires and holds a lock state and flags and counts sequence faults. It sits at the consuming end of the phase bus and drives phase-dependent logic and fault reporting.

## Interface
- LOCK_COUNT, 4, consecutive correct phase advances required to enter LOCKED (legal range 1..15)
- CNT_W, 8, width of the saturating error counter
- clk  input  1  clock; all sampling and state updates on its rising edge
- reset  input  1  asynchronous, active-low
- signal  input  4  one-hot phase code; 1000 = phase 0, 0100 = phase 1, 0010 = phase 2, 0001 = phase 3
- index  output  2  decoded phase of the registered sample; 0 when the sample is illegal
- valid  output  1  registered sample is a legal one-hot code
- locked  output  1  FSM is in LOCKED
- err  output  1  one-cycle pulse on each sequence fault detected while LOCKED
- err_count  output  CNT_W  number of faults since reset, saturating at all-ones

## Operation
- Input stage: `sample_q <= signal` on every edge. `index` and `valid` are combinational decodes of `sample_q`.
- Legal codes are exactly the four one-hot values. 0000, multi-hot and all other values are illegal: `valid`=0 and `index`=0.
- Internal registers:
  - `prev_idx[1:0]`: last legal phase accepted.
  - `run[3:0]`: count of consecutive correct advances.
  - FSM state.
- Expected phase is `prev_idx+1` mod 4. 3 wraps to 0.
- FSM states and transitions, evaluated on each edge using the current `sample_q`:
  - SEARCH (reset state):
    - Illegal code: stay.
    - Legal code: go to TRACK, `prev_idx`=index, `run`=0.
  - TRACK:
    - Illegal code: go to SEARCH, `run`=0.
    - Legal code but not the expected phase (includes a repeated or stalled phase): stay in TRACK, `prev_idx`=index, `run`=0.
    - Expected phase: `prev_idx`=index, `run`++. When `run`+1 == LOCK_COUNT, go to LOCKED.
  - LOCKED:
    - Expected phase: stay, `prev_idx`=index.
    - Illegal code: fault; go to SEARCH.
    - Legal but unexpected phase (skip, stall or reverse): fault; go to TRACK with `prev_idx`=index, `run`=0.
- Fault handling:
  - Each fault sets `err`=1 for exactly one cycle.
  - Each fault increments `err_count`. The counter holds at 2^CNT_W−1 once it gets there.
  - Mismatches in SEARCH or TRACK are not faults: no `err` pulse and no count.
- `locked` is a registered decode of the state and deasserts on the same edge that raises `err`.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - `sample_q`=0000, `index`=0, `valid`=0, `locked`=0, `err`=0, `err_count`=0.
  - State SEARCH, `prev_idx`=0, `run`=0.
- Deassertion of `reset` takes effect at the next rising edge.
- Latency of `index`/`valid`: valid immediately after the edge that samples `signal`, i.e. 1 clock of latency.
- Latency of `err`/`locked`/`err_count`: they change on the edge after the sampling edge, i.e. 2 clocks after `signal` is presented.
- Lock acquisition: with a clean sequence presented from reset release, `locked` rises after LOCK_COUNT+2 edges.
  - The first edge samples the first code.
  - The next edge enters TRACK.
  - The following LOCK_COUNT edges each accept one correct advance.
- Back-to-back faults in LOCKED cannot occur, because the first fault leaves LOCKED. The next `err` pulse requires a full re-lock.
- Reset asserted mid-LOCKED or mid-TRACK clears everything immediately with no clock, including `err_count`. Any `err` pulse in flight is cut.

## Test plan
- Reset: hold `reset`=0 across 3 edges while toggling `signal` → `index`=0, `valid`=0, `locked`=0, `err`=0, `err_count`=0 throughout.
- Acquisition (LOCK_COUNT=4): release reset, then drive 1000, 0100, 0010, 0001, 1000, … one code per clock.
  - `valid`=1 and `index` follows 0,1,2,3,0 one cycle behind `signal`.
  - `locked` rises 6 edges after release and stays high for 20 further cycles, including across the 3→0 wrap, with `err`=0.
- Illegal code while LOCKED: inject 0110 for one cycle.
  - `valid`=0 and `index`=0 for that sample.
  - One cycle later: `err`=1 for one cycle, `err_count`=1, `locked`=0.
  - Clean sequence resumes → `locked` re-asserts 6 edges after the first legal code.
- Order faults while LOCKED:
  - Skip 1000→0010 → `err` pulse, `err_count` increments, TRACK with `prev_idx`=2.
  - Continuing 0001, 1000, 0100, 0010 → re-lock after 4 advances with no fault pulse during TRACK.
  - Repeat with stall 0100,0100 and with reverse 0010→0100 → one fault each.
- Saturation (CNT_W=3): produce 10 faults, each followed by a re-lock → `err_count` reads 1..7, then holds at 7. `err` still pulses for faults 8–10.
- Async reset mid-operation: while LOCKED with `err_count`=2, pull `reset` low between clock edges.
  - All outputs clear immediately, before the next edge.
  - After release, the acquisition behaviour repeats exactly.
